// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide execute unit with stall and result pulse
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvsr_r;
  logic            q_neg;
  logic            r_neg;
  logic            mod_r;

  logic            accept;
  logic            op_div;
  logic            op_sdiv;
  logic            op_mod;
  logic            mul_signed;
  logic            mul_high;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] div0_res;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            step_ok;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign accept     = (state == IDLE) && start && !flush;
  assign op_div     = (op >= 3'd3) && (op <= 3'd6);
  assign op_sdiv    = (op == 3'd3) || (op == 3'd4);
  assign op_mod     = (op == 3'd4) || (op == 3'd6);
  assign mul_signed = (op != 3'd2);
  assign mul_high   = (op == 3'd1) || (op == 3'd2);

  // Sign- or zero-extend to full product width so one multiplier serves all variants.
  assign mul_a   = {{XLEN{mul_signed & src_a[XLEN-1]}}, src_a};
  assign mul_b   = {{XLEN{mul_signed & src_b[XLEN-1]}}, src_b};
  assign prod    = mul_a * mul_b;
  assign mul_res = mul_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  assign abs_a    = (op_sdiv && src_a[XLEN-1]) ? -src_a : src_a;
  assign abs_b    = (op_sdiv && src_b[XLEN-1]) ? -src_b : src_b;
  assign div0_res = op_mod ? src_a : {XLEN{1'b1}};

  // Restoring step: remainder carries one extra bit so the trial subtract sign is exact.
  assign rem_sh  = {rem_r, quo_r[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvsr_r};
  assign step_ok = ~diff[XLEN];
  assign rem_nx  = step_ok ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {quo_r[XLEN-2:0], step_ok};
  assign quo_fix = q_neg ? -quo_nx : quo_nx;
  assign rem_fix = r_neg ? -rem_nx : rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rem_r        <= '0;
      quo_r        <= '0;
      dvsr_r       <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      mod_r        <= 1'b0;
      ready        <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else if (flush) begin
      state        <= IDLE;
      ready        <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_div && (src_b != '0)) begin
              state  <= CALC;
              ready  <= 1'b0;
              busy   <= 1'b1;
              cnt    <= '0;
              rem_r  <= '0;
              quo_r  <= abs_a;
              dvsr_r <= abs_b;
              q_neg  <= op_sdiv & (src_a[XLEN-1] ^ src_b[XLEN-1]);
              r_neg  <= op_sdiv & src_a[XLEN-1];
              mod_r  <= op_mod;
            end else begin
              state        <= DONE;
              ready        <= 1'b0;
              result_valid <= 1'b1;
              result       <= op_div ? div0_res : mul_res;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            result       <= mod_r ? rem_fix : quo_fix;
          end
        end
        default: begin
          state        <= IDLE;
          ready        <= 1'b1;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_res;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .ready(ready), .busy(busy), .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd3: begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
      3'd4: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : a % b;
      default: begin p = sa * sb; return p[31:0]; end
    endcase
  endfunction

  // Issue one op from IDLE and check latency, busy span, result and return to IDLE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int exp_lat, lat, busy_cnt;
    exp     = model(o, a, b);
    exp_lat = (o >= 3 && o <= 6 && b != 0) ? 33 : 1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1; busy_cnt = 0;
    while (!result_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("lat op%0d", o), lat, exp_lat);
    chk($sformatf("busy_cycles op%0d", o), busy_cnt, exp_lat - 1);
    chk($sformatf("result op%0d a=%h b=%h", o, a, b), result, exp);
    @(negedge clk);
    chk("ready_after", {ready, busy, result_valid}, 3'b100);
    chk("result_held", result, exp);
    last_res = exp;
  endtask

  initial begin
    int valids;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {ready, busy, result_valid}, 3'b100);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd3, 32'd7, 32'd2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1);
    run_op(3'd6, 32'd10, 32'd3);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd3, 32'd5, 32'd0);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd1234, 32'hFFFF_FF00);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op(ro, ra, rb);
    end

    // Flush mid-divide, with a start issued while busy that must be ignored.
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("start_while_busy", {ready, busy, result_valid}, 3'b010);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ctl", {ready, busy, result_valid}, 3'b100);
    chk("flush_result", result, last_res);
    valids = 0;
    repeat (40) begin @(negedge clk); if (result_valid) valids++; end
    chk("flush_no_valid", valids, 0);

    start = 1'b1; flush = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush_ctl", {ready, busy, result_valid}, 3'b100);
    chk("start_flush_result", result, last_res);

    // Asynchronous reset mid-divide.
    start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctl", {ready, busy, result_valid}, 3'b100);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    valids = 0;
    repeat (40) begin @(negedge clk); if (result_valid) valids++; end
    chk("rst_no_valid", valids, 0);
    chk("rst_idle", {ready, busy}, 2'b10);

    run_op(3'd5, 32'd99, 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle execute-stage unit for the MUL, MULH, MULHU, DIV, MOD, DIVU and MODU instructions.
- Owns an iterative radix-2 restoring divider and a registered 32x32 multiplier, sequenced by an FSM.
- Drives a busy/stall signal back to the pipeline while an operation is in flight.
- Delivers a one-cycle result_valid pulse, with the result held, for the writeback path.

Parameters:
XLEN, 32, operand/result width; the divider iteration count equals XLEN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  request; accepted only when ready=1 and flush=0.
op  in  3  0=MUL 1=MULH 2=MULHU 3=DIV 4=MOD 5=DIVU 6=MODU; 7 reserved.
src_a  in  XLEN  rj operand (dividend / multiplicand).
src_b  in  XLEN  rk operand (divisor / multiplier).
flush  in  1  pipeline flush; aborts the current operation.
ready  out  1  high only in IDLE.
busy  out  1  stall request; high in CALC.
result_valid  out  1  one-cycle pulse in DONE.
result  out  XLEN  result; held from DONE until the next accept.

Behaviour:
- Reset (async, rst=1): state=IDLE; ready=1; busy=0; result_valid=0; result=0; all internal registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch op/src_a/src_b; go to CALC for ops 3-6; go to DONE for ops 0-2.
  - op=7: treated as MUL.
- Multiply:
  - Product is computed combinationally at accept and registered. The 64-bit signed product is used for MUL/MULH; the unsigned product for MULHU.
  - MUL returns low XLEN bits; MULH and MULHU return high XLEN bits.
  - Latency: accept at cycle 0, result_valid at cycle 1, back in IDLE at cycle 2.
- Divide, at accept:
  - Signed ops use |src_a| and |src_b|.
  - Record q_neg = sign(a) XOR sign(b) and r_neg = sign(a); both are 0 for unsigned ops.
  - Iteration counter is cleared.
- CALC:
  - One restoring step per cycle, for XLEN cycles (cycles 1..XLEN).
  - Each step shifts {rem,quo} left by 1, trial-subtracts the divisor from rem, and sets the quotient bit when the difference is non-negative.
  - Counter width is clog2(XLEN)+1.
  - On the last step, apply the sign fix (negate quo if q_neg, negate rem if r_neg), register the result, and go to DONE.
  - DIV/DIVU yield quo; MOD/MODU yield rem.
  - Latency: accept at cycle 0, result_valid at cycle XLEN+1 (33), ready again at cycle XLEN+2.
- Divide by zero (src_b=0):
  - Skip CALC and go directly to DONE, latency 1 as for multiply.
  - DIV/DIVU return all ones. MOD/MODU return src_a unchanged.
- Signed overflow (DIV 0x80000000 / -1): needs no special path. The result is 0x80000000 from DIV and 0 from MOD, with the quotient truncated to XLEN bits.
- DONE: result_valid=1 for exactly one cycle, then IDLE unconditionally.
- busy = (state==CALC). The pipeline holds the instruction in EX while busy=1 and consumes the result on result_valid.
- start while not IDLE: ignored; no state change and no queueing.
- flush=1 in any state: next state IDLE; any pending result_valid is suppressed; result keeps its old value.
- flush and start in the same IDLE cycle: flush wins; the request is not accepted.
- Reset asserted mid-operation: immediate return to IDLE with reset values; no result_valid.
- Operands are sampled only at accept. Changes to src_a/src_b/op after accept have no effect.

Test Plan:
- Reset, then DIV a=7 b=2 at cycle 0 -> busy high cycles 1-32; result_valid at cycle 33 with result=3; ready=1 at cycle 34.
- MOD a=-7 (0xFFFFFFF9) b=2 -> result=0xFFFFFFFF (-1); DIVU a=0xFFFFFFFF b=1 -> result=0xFFFFFFFF; MODU a=10 b=3 -> 1.
- MULH a=0x80000000 b=0x80000000 -> result=0x40000000 at cycle 1; MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE; MUL a=-3 b=5 -> 0xFFFFFFF1.
- DIV a=5 b=0 -> result=0xFFFFFFFF at cycle 1; MOD a=5 b=0 -> 5; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, and MOD of the same operands -> 0.
- DIV accepted, flush at cycle 10 -> IDLE at cycle 11, no result_valid pulse, result unchanged. A start at cycle 5 (while busy) is ignored. Start and flush in the same IDLE cycle -> not accepted.
- rst asserted asynchronously at cycle 15 of a DIV -> outputs at reset values immediately; no result_valid after rst deasserts.
